fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding a DEPTH-entry prefetch FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN enables the sticky misalign_err flag for redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        misalign_err,
    output logic [1:0]  dbgState
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Handshakes: imem_req/imem_addr are held until the cycle imem_ack=1 completes the
    // request; an entry leaves the buffer in any cycle with instr_valid && instr_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT state, nextState;

    logic [31:0]   fetchPc;
    logic [31:0]   pendPc;
    logic [31:0]   pcMem   [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count, countNext;
    logic [31:0]   target;
    logic          push, pop;

    assign target    = {redirect_addr[31:2], 2'b00};
    assign push      = (state == REQ) && imem_ack && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;
    assign countNext = count + CW'(push) - CW'(pop);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (redirect || (count < FULL)) nextState = REQ;
            end
            REQ: begin
                if (redirect)      nextState = imem_ack ? REQ : FLUSH;
                else if (imem_ack) nextState = (countNext < FULL) ? REQ : IDLE;
            end
            FLUSH: begin
                if (imem_ack) nextState = REQ;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            pendPc  <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            state <= nextState;
            if (redirect) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= (wrPtr == LAST) ? '0 : wrPtr + PW'(1);
                if (pop)  rdPtr <= (rdPtr == LAST) ? '0 : rdPtr + PW'(1);
                count <= countNext;
            end
            // While a request is still in flight the address must stay put, so the
            // redirect target waits in pendPc until the ack retires it.
            if (redirect) begin
                if ((state != IDLE) && !imem_ack) pendPc  <= target;
                else                              fetchPc <= target;
            end else if ((state == FLUSH) && imem_ack) begin
                fetchPc <= pendPc;
            end else if (push) begin
                fetchPc <= fetchPc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pcMem[wrPtr]   <= fetchPc;
            dataMem[wrPtr] <= imem_rdata;
        end
    end

    assign imem_req    = (state == REQ) || (state == FLUSH);
    assign imem_addr   = fetchPc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? dataMem[rdPtr] : 32'h0;
    assign instr_pc    = instr_valid ? pcMem[rdPtr] : 32'h0;
    assign dbgState    = state;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalignReg;

    always_ff @(posedge clk) begin
        if (rst)                                         misalignReg <= 1'b0;
        else if (redirect && (redirect_addr[1:0] != 2'b00)) misalignReg <= 1'b1;
    end

    assign misalign_err = misalignReg;
`else
    logic unusedAddrBits;

    assign unusedAddrBits = ^redirect_addr[1:0];
    assign misalign_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: sequential-stream model, request-hold property,
// and directed scenarios (latency, back-pressure, flush, reset, wrap, misalignment).
module tb_fetch_unit;
    localparam logic [31:0] W_RESET    = 32'hFFFF_FFF8;
    localparam int          ACK_NONE   = 0;
    localparam int          ACK_ALWAYS = 1;
    localparam int          ACK_HOLD   = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic        EXP_MIS    = 1'b1;
`else
    localparam logic        EXP_MIS    = 1'b0;
`endif

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        misalign_err;
    logic [1:0]  dbgState;

    logic        wReq, wValid, wMis;
    logic [31:0] wAddr, wRdata, wInstr, wPc;
    logic [1:0]  wState;

    int          ackMode;
    logic [31:0] holdAddr;
    int          compared, mismatched;

    logic [31:0] exp_q[$];
    logic [31:0] wSeen[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .misalign_err(misalign_err), .dbgState(dbgState)
    );

    fetch_unit #(.RESET_PC(W_RESET)) dutWrap (
        .clk(clk), .rst(rst),
        .imem_req(wReq), .imem_addr(wAddr), .imem_ack(1'b1), .imem_rdata(wRdata),
        .instr_valid(wValid), .instr(wInstr), .instr_pc(wPc), .instr_ready(1'b1),
        .redirect(1'b0), .redirect_addr(32'h0),
        .misalign_err(wMis), .dbgState(wState)
    );

    // clock / memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_ack   = (ackMode == ACK_ALWAYS) ||
                     ((ackMode == ACK_HOLD) && imem_req && (imem_addr != holdAddr));
        imem_rdata = memWord(imem_addr);
        wRdata     = memWord(wAddr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // model: the core sees consecutive word addresses from the latest start point
    logic [31:0] expPc, wExpPc, prevAddr;
    logic        expEmpty, prevPending;

    always @(negedge clk) begin
        if (rst) begin
            expPc       = 32'h0;
            wExpPc      = W_RESET;
            expEmpty    = 1'b0;
            prevPending = 1'b0;
        end else begin
            if (instr_valid) begin
                check("stream_pc", instr_pc, expPc);
                check("stream_data", instr, memWord(expPc));
            end
            if (expEmpty) check("flush_empty", {31'b0, instr_valid}, 32'h0);
            if (prevPending) begin
                check("req_hold", {31'b0, imem_req}, 32'h1);
                check("addr_hold", imem_addr, prevAddr);
            end
            prevPending = imem_req && !imem_ack;
            prevAddr    = imem_addr;
            expEmpty    = redirect;
            if (redirect)                        expPc = {redirect_addr[31:2], 2'b00};
            else if (instr_valid && instr_ready) expPc = expPc + 32'd4;
            if (wValid) begin
                check("wrap_stream_pc", wPc, wExpPc);
                check("wrap_stream_data", wInstr, memWord(wExpPc));
                if (wSeen.size() < 3) wSeen.push_back(wPc);
                wExpPc = wExpPc + 32'd4;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        logic found;
        compared = 0; mismatched = 0;
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
        ackMode = ACK_NONE; holdAddr = 32'h0;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        repeat (3) tick();

        // reset values
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_mis", {31'b0, misalign_err}, 32'h0);

        // streaming, first-request timing, latency; acks with req=0 are ignored
        tick(); rst = 1'b0; ackMode = ACK_ALWAYS; instr_ready = 1'b1;
        @(negedge clk); check("c0_req", {31'b0, imem_req}, 32'h0);
        tick(); @(negedge clk);
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        tick(); @(negedge clk);
        check("lat_valid", {31'b0, instr_valid}, 32'h1);
        check("lat_pc", instr_pc, 32'h0);
        check("lat_data", instr, 32'hC0DE_0000);
        tick(); @(negedge clk); check("seq_pc4", instr_pc, 32'h4);  check("seq_d4", instr, 32'hC0DE_0004);
        tick(); @(negedge clk); check("seq_pc8", instr_pc, 32'h8);
        tick(); @(negedge clk); check("seq_pc12", instr_pc, 32'hC);
        repeat (6) tick();

        // back-pressure: exactly DEPTH requests, then one per pop
        instr_ready = 1'b0;
        doReset();
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); @(negedge clk);
            if (imem_req && imem_ack) reqs++;
        end
        check("full_reqs", reqs, 32'd4);
        check("full_idle", {31'b0, imem_req}, 32'h0);
        check("full_head", instr_pc, 32'h0);
        tick(); instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) reqs++;
            tick();
        end
        check("refill_reqs", reqs, 32'd1);
        check("refill_head", instr_pc, 32'h4);
        check("refill_idle", {31'b0, imem_req}, 32'h0);

        // redirect while the request to 0x8 is still waiting
        instr_ready = 1'b1; ackMode = ACK_HOLD; holdAddr = 32'h8;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); @(negedge clk);
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        check("wait_req8", {31'b0, found}, 32'h1);
        tick(); redirect = 1'b1; redirect_addr = 32'h40;
        @(negedge clk); check("fl_addr0", imem_addr, 32'h8);
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("fl_req", {31'b0, imem_req}, 32'h1);
        check("fl_addr1", imem_addr, 32'h8);
        check("fl_empty", {31'b0, instr_valid}, 32'h0);
        tick(); @(negedge clk); check("fl_addr2", imem_addr, 32'h8);
        tick(); ackMode = ACK_ALWAYS;
        @(negedge clk); check("fl_addr3", imem_addr, 32'h8);
        tick(); @(negedge clk);
        check("fl_new_req", {31'b0, imem_req}, 32'h1);
        check("fl_new_addr", imem_addr, 32'h40);
        tick(); @(negedge clk);
        check("fl_new_valid", {31'b0, instr_valid}, 32'h1);
        check("fl_new_pc", instr_pc, 32'h40);
        check("fl_new_data", instr, 32'hC0DE_0040);
        repeat (3) tick();

        // redirect together with ack and pop, two entries buffered
        instr_ready = 1'b0; ackMode = ACK_HOLD; holdAddr = 32'h8;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); @(negedge clk);
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        check("wait_two", {31'b0, found}, 32'h1);
        check("two_head", instr_pc, 32'h0);
        tick(); ackMode = ACK_ALWAYS; instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h80;
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("co_valid", {31'b0, instr_valid}, 32'h0);
        check("co_req", {31'b0, imem_req}, 32'h1);
        check("co_addr", imem_addr, 32'h80);
        tick(); @(negedge clk);
        check("co_pc", instr_pc, 32'h80);
        check("co_data", instr, 32'hC0DE_0080);
        repeat (3) tick();

        // reset mid-request, also overriding a redirect; later acks ignored
        ackMode = ACK_HOLD; holdAddr = 32'h4;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); @(negedge clk);
            if (imem_req && imem_addr == 32'h4) found = 1'b1;
        end
        check("wait_req4", {31'b0, found}, 32'h1);
        tick(); rst = 1'b1; redirect = 1'b1; redirect_addr = 32'h300;
        tick(); rst = 1'b0; redirect = 1'b0; ackMode = ACK_ALWAYS;
        @(negedge clk);
        check("rr_req", {31'b0, imem_req}, 32'h0);
        check("rr_valid", {31'b0, instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("rr_addr", imem_addr, 32'h0);
        tick(); @(negedge clk);
        check("rr_pc", instr_pc, 32'h0);
        repeat (3) tick();

        // misaligned redirect from a full, idle buffer
        instr_ready = 1'b0; ackMode = ACK_ALWAYS;
        doReset();
        repeat (8) tick();
        redirect = 1'b1; redirect_addr = 32'h102;
        tick(); redirect = 1'b0;
        @(negedge clk);
        check("mis_flag", {31'b0, misalign_err}, {31'b0, EXP_MIS});
        check("mis_req", {31'b0, imem_req}, 32'h1);
        check("mis_addr", imem_addr, 32'h100);
        check("mis_empty", {31'b0, instr_valid}, 32'h0);
        tick(); @(negedge clk);
        check("mis_pc", instr_pc, 32'h100);
        check("mis_data", instr, 32'hC0DE_0100);
        tick(); redirect = 1'b1; redirect_addr = 32'h200;
        tick(); redirect = 1'b0;
        @(negedge clk); check("mis_sticky", {31'b0, misalign_err}, {31'b0, EXP_MIS});
        doReset();
        @(negedge clk); check("mis_cleared", {31'b0, misalign_err}, 32'h0);

        // wrap-around instance
        check("wrap_count", wSeen.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wSeen.size()) check("wrap_pc", wSeen[i], exp_q[i]);
        end
        check("wrap_mis", {31'b0, wMis}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
